// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with an optional two-entry skid
// buffer, flush-to-bubble squashing and saturating stall/flush counters.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// FULL  | head register holds the oldest entry
// SKID  | head and skid registers both hold entries (SKID_EN=1 only)
module pipe_stage_skid #(
   parameter int unsigned DataWidth = 96,
   parameter int unsigned CtrlWidth = 24,
   parameter bit          SKID_EN   = 1'b1,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DataWidth-1:0] in_data,
   input  logic [CtrlWidth-1:0] in_ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataWidth-1:0] out_data,
   output logic [CtrlWidth-1:0] out_ctrl,
   input  logic                 flush,
   input  logic                 clr_cnt,
   output logic [CntWidth-1:0]  stall_cnt,
   output logic [CntWidth-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   localparam logic [CntWidth-1:0] CntMax = '1;

   state_t               state;
   state_t               state_nxt;
   logic [DataWidth-1:0] main_data;
   logic [CtrlWidth-1:0] main_ctrl;
   logic [DataWidth-1:0] skid_data;
   logic [CtrlWidth-1:0] skid_ctrl;
   logic                 ld_main_in;
   logic                 ld_main_skid;
   logic                 ld_skid;
   logic                 xfer_in;
   logic                 xfer_out;

   assign out_valid = (state != ST_EMPTY);

   // In skid mode in_ready is a pure state decode, which cuts the
   // out_ready -> in_ready timing path between stages.
   assign in_ready  = SKID_EN ? (state != ST_SKID) : (!out_valid || out_ready);

   assign xfer_in   = in_valid && in_ready;
   assign xfer_out  = out_valid && out_ready;

   assign out_data  = main_data;
   assign out_ctrl  = out_valid ? main_ctrl : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else if (SKID_EN) begin
         case (state)
            ST_EMPTY: begin
               if (in_valid) begin
                  state_nxt  = ST_FULL;
                  ld_main_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (in_valid && out_ready) begin
                  ld_main_in = 1'b1;
               end else if (in_valid) begin
                  state_nxt = ST_SKID;
                  ld_skid   = 1'b1;
               end else if (out_ready) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  state_nxt    = ST_FULL;
                  ld_main_skid = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end else begin
         if (xfer_in) begin
            state_nxt  = ST_FULL;
            ld_main_in = 1'b1;
         end else if (xfer_out) begin
            state_nxt = ST_EMPTY;
         end
      end
   end

   // Data registers are not cleared by flush; the bubble is expressed by state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_data <= '0;
         main_ctrl <= '0;
      end else if (ld_main_in) begin
         main_data <= in_data;
         main_ctrl <= in_ctrl;
      end else if (ld_main_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (ld_skid) begin
         skid_data <= in_data;
         skid_ctrl <= in_ctrl;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CntMax)) begin
         stall_cnt <= stall_cnt + CntWidth'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flush_cnt <= '0;
      end else if (clr_cnt) begin
         flush_cnt <= '0;
      end else if (flush && (flush_cnt != CntMax)) begin
         flush_cnt <= flush_cnt + CntWidth'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized scoreboard bench for pipe_stage_skid: one skid-mode and one
// direct-mode instance, each checked against a queue-based occupancy model.
module tb_pipe_stage_skid;

   localparam int DW   = 96;
   localparam int CW   = 24;
   localparam int NW   = 4;
   localparam int N    = 2;
   localparam int CMAX = 15;
   localparam int NCYC = 600;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid  [N];
   logic          in_ready  [N];
   logic [DW-1:0] in_data   [N];
   logic [CW-1:0] in_ctrl   [N];
   logic          out_valid [N];
   logic          out_ready [N];
   logic [DW-1:0] out_data  [N];
   logic [CW-1:0] out_ctrl  [N];
   logic          flush     [N];
   logic          clr_cnt   [N];
   logic [NW-1:0] stall_cnt [N];
   logic [NW-1:0] flush_cnt [N];

   logic [DW+CW-1:0] exp_q [N][$];
   int               exp_stall [N];
   int               exp_flush [N];
   bit               m_out_valid [N];
   bit               m_in_ready  [N];
   int               checks   = 0;
   int               failures = 0;
   bit               running  = 1'b0;

   always #5 clock = ~clock;

   pipe_stage_skid #(.DataWidth(DW), .CtrlWidth(CW), .SKID_EN(1'b1), .CntWidth(NW)) u_skid (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
      .flush(flush[0]), .clr_cnt(clr_cnt[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
   );

   pipe_stage_skid #(.DataWidth(DW), .CtrlWidth(CW), .SKID_EN(1'b0), .CntWidth(NW)) u_direct (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
      .flush(flush[1]), .clr_cnt(clr_cnt[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
   );

   task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, req);
      end
   endtask

   // Instance 0 can hold two entries and stalls only when both are held;
   // instance 1 holds one and may accept while its entry is leaving.
   function automatic bit model_in_ready(input int i);
      if (i == 0) return exp_q[i].size() < 2;
      return (exp_q[i].size() == 0) || out_ready[i];
   endfunction

   // Monitor: compares DUT outputs against the model and retires consumed entries.
   always @(negedge clock) begin
      if (running) begin
         for (int i = 0; i < N; i++) begin
            check("out_valid", i, 128'(out_valid[i]), 128'(exp_q[i].size() != 0));
            check("in_ready", i, 128'(in_ready[i]), 128'(model_in_ready(i)));
            check("stall_cnt", i, 128'(stall_cnt[i]), 128'(exp_stall[i]));
            check("flush_cnt", i, 128'(flush_cnt[i]), 128'(exp_flush[i]));
            if (exp_q[i].size() != 0) begin
               check("out_entry", i, 128'({out_data[i], out_ctrl[i]}), 128'(exp_q[i][0]));
               if (out_ready[i]) void'(exp_q[i].pop_front());
            end else begin
               check("bubble_ctrl", i, 128'(out_ctrl[i]), 128'(0));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         in_valid[i] = 1'b0; in_data[i] = '0; in_ctrl[i] = '0;
         out_ready[i] = 1'b0; flush[i] = 1'b0; clr_cnt[i] = 1'b0;
         exp_stall[i] = 0; exp_flush[i] = 0;
      end
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         check("rst_out_valid", i, 128'(out_valid[i]), 128'(0));
         check("rst_in_ready", i, 128'(in_ready[i]), 128'(1));
         check("rst_out_data", i, 128'(out_data[i]), 128'(0));
         check("rst_out_ctrl", i, 128'(out_ctrl[i]), 128'(0));
         check("rst_stall_cnt", i, 128'(stall_cnt[i]), 128'(0));
         check("rst_flush_cnt", i, 128'(flush_cnt[i]), 128'(0));
      end
      @(negedge clock);
      reset = 1'b1;
      #1 running = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clock);
         #1;
         for (int i = 0; i < N; i++) begin
            m_out_valid[i] = (exp_q[i].size() != 0);
            flush[i]   = 1'b0;
            clr_cnt[i] = 1'b0;
            if (c < 20) begin
               in_valid[i] = 1'b1; out_ready[i] = 1'b1;
               in_data[i] = DW'(c); in_ctrl[i] = CW'(c + 1);
            end else if (c < 41) begin
               in_valid[i] = 1'b1; out_ready[i] = 1'b0;
               in_data[i] = DW'(c); in_ctrl[i] = CW'(c + 1);
               clr_cnt[i] = (c == 40);
            end else begin
               in_valid[i]  = ($urandom_range(0, 3) != 0);
               out_ready[i] = (((c / 50) % 3) == 2) ? ($urandom_range(0, 9) == 0)
                                                     : ($urandom_range(0, 2) != 0);
               flush[i]     = (c == 45) || ($urandom_range(0, 19) == 0);
               clr_cnt[i]   = (c == 45) || ($urandom_range(0, 39) == 0);
               in_data[i]   = {$urandom, $urandom, $urandom};
               in_ctrl[i]   = CW'($urandom);
            end
            m_in_ready[i] = model_in_ready(i);
         end
         @(negedge clock);
         #1;
         for (int i = 0; i < N; i++) begin
            if (clr_cnt[i]) exp_stall[i] = 0;
            else if (m_out_valid[i] && !out_ready[i] && exp_stall[i] < CMAX) exp_stall[i]++;
            if (clr_cnt[i]) exp_flush[i] = 0;
            else if (flush[i] && exp_flush[i] < CMAX) exp_flush[i]++;
            if (flush[i]) exp_q[i].delete();
            else if (in_valid[i] && m_in_ready[i]) exp_q[i].push_back({in_data[i], in_ctrl[i]});
         end
      end
      running = 1'b0;

      // Fill both stages, then assert reset between clock edges.
      for (int i = 0; i < N; i++) begin
         in_valid[i] = 1'b1; out_ready[i] = 1'b0; flush[i] = 1'b0; clr_cnt[i] = 1'b0;
         in_data[i] = {$urandom, $urandom, $urandom}; in_ctrl[i] = CW'($urandom | 1);
      end
      repeat (2) @(posedge clock);
      #3;
      for (int i = 0; i < N; i++) check("pre_rst_valid", i, 128'(out_valid[i]), 128'(1));
      reset = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check("async_out_valid", i, 128'(out_valid[i]), 128'(0));
         check("async_out_ctrl", i, 128'(out_ctrl[i]), 128'(0));
         check("async_in_ready", i, 128'(in_ready[i]), 128'(1));
         check("async_stall_cnt", i, 128'(stall_cnt[i]), 128'(0));
         check("async_flush_cnt", i, 128'(flush_cnt[i]), 128'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
